// File: rtl/instr_fetch_router_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : instr_router_pkg                                                 |
// | Brief   : Tag encoding helpers and default device map for the fetch router |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
package instr_router_pkg;

    localparam int unsigned c_max_nr_devices = 8;

    // Tags 0..NrDevices-1 name a device; the extra code NrDevices marks an unmapped fetch.
    function automatic int unsigned tag_width(input int unsigned nr_devices);
        return $clog2(nr_devices + 1);
    endfunction

    function automatic int unsigned tag_err(input int unsigned nr_devices);
        return nr_devices;
    endfunction

    localparam logic [31:0] c_ram_base = 32'h0010_0000;
    localparam logic [31:0] c_ram_mask = 32'hFFFF_0000;
    localparam logic [31:0] c_dbg_base = 32'h1A11_0000;
    localparam logic [31:0] c_dbg_mask = 32'hFFFF_0000;

endpackage
`default_nettype wire

// File: rtl/instr_fetch_router_tag_fifo.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : instr_router_tag_fifo                                            |
// | Brief   : Small in-order FIFO holding the routing tag of each fetch        |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module instr_router_tag_fifo #(
    parameter int unsigned Depth = 2,
    parameter int unsigned Width = 2
) (
    input  logic                           clk_sys_i,
    input  logic                           rst_sys_ni,
    input  logic                           push_i,
    input  logic [Width-1:0]               data_i,
    input  logic                           pop_i,
    output logic [Width-1:0]               head_o,
    output logic                           empty_o,
    output logic                           full_o,
    output logic [$clog2(Depth+1)-1:0]     count_o
);

    localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;
    localparam int unsigned CntW = $clog2(Depth + 1);
    localparam logic [PtrW-1:0] c_last_ptr = PtrW'(Depth - 1);
    localparam logic [CntW-1:0] c_depth    = CntW'(Depth);

    logic [Width-1:0] r_mem [Depth];
    logic [PtrW-1:0]  r_wr_ptr;
    logic [PtrW-1:0]  r_rd_ptr;
    logic [CntW-1:0]  r_count;
    logic             w_do_push;
    logic             w_do_pop;

    // Depth need not be a power of two, so wrap on an explicit compare.
    function automatic logic [PtrW-1:0] next_ptr(input logic [PtrW-1:0] ptr);
        return (ptr == c_last_ptr) ? '0 : ptr + 1'b1;
    endfunction

    assign empty_o   = (r_count == '0);
    assign full_o    = (r_count == c_depth);
    assign count_o   = r_count;
    assign head_o    = r_mem[r_rd_ptr];
    assign w_do_push = push_i & (~full_o | pop_i);
    assign w_do_pop  = pop_i & ~empty_o;

    always_ff @(posedge clk_sys_i or negedge rst_sys_ni) begin
        if (!rst_sys_ni) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= next_ptr(r_wr_ptr);
            if (w_do_pop)  r_rd_ptr <= next_ptr(r_rd_ptr);
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk_sys_i) begin
        if (w_do_push) r_mem[r_wr_ptr] <= data_i;
    end

endmodule
`default_nettype wire

// File: rtl/instr_fetch_router.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : instr_fetch_router                                               |
// | Brief   : Routes core instruction fetches to N devices, responses in order |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module instr_fetch_router
    import instr_router_pkg::*;
#(
    parameter int unsigned NrDevices      = 2,
    parameter int unsigned AddressWidth   = 32,
    parameter int unsigned DataWidth      = 32,
    parameter int unsigned MaxOutstanding = 2
) (
    input  logic                                     clk_sys_i,
    input  logic                                     rst_sys_ni,
    input  logic                                     host_req_i,
    output logic                                     host_gnt_o,
    input  logic [AddressWidth-1:0]                  host_addr_i,
    output logic                                     host_rvalid_o,
    output logic [DataWidth-1:0]                     host_rdata_o,
    output logic                                     host_err_o,
    output logic [NrDevices-1:0]                     dev_req_o,
    input  logic [NrDevices-1:0]                     dev_gnt_i,
    output logic [AddressWidth-1:0]                  dev_addr_o,
    input  logic [NrDevices-1:0]                     dev_rvalid_i,
    input  logic [NrDevices-1:0][DataWidth-1:0]      dev_rdata_i,
    input  logic [NrDevices-1:0]                     dev_err_i,
    input  logic [NrDevices-1:0][AddressWidth-1:0]   cfg_device_addr_base_i,
    input  logic [NrDevices-1:0][AddressWidth-1:0]   cfg_device_addr_mask_i,
    output logic                                     idle_o,
    output logic                                     stray_rsp_o
);

    localparam int unsigned     TagW      = tag_width(NrDevices);
    localparam int unsigned     CntW      = $clog2(MaxOutstanding + 1);
    localparam logic [TagW-1:0] c_tag_err = TagW'(tag_err(NrDevices));

    logic [NrDevices-1:0] w_match;
    logic [NrDevices-1:0] w_sel_oh;
    logic [TagW-1:0]      w_sel_tag;
    logic                 w_mapped;
    logic                 w_space;
    logic                 w_push;
    logic                 w_pop;
    logic                 w_stray;
    logic                 w_empty;
    logic                 w_full;
    logic [TagW-1:0]      w_head;
    logic [CntW-1:0]      w_count;
    logic [CntW:0]        w_count_nxt;
    logic                 r_stray;
    logic                 r_idle;

    for (genvar i = 0; i < NrDevices; i++) begin : g_decode
        assign w_match[i] = ((host_addr_i & cfg_device_addr_mask_i[i]) == cfg_device_addr_base_i[i]);
    end

    // Scan downwards so the lowest matching index is the one left standing.
    always_comb begin : p_select
        w_mapped  = 1'b0;
        w_sel_oh  = '0;
        w_sel_tag = c_tag_err;
        for (int i = NrDevices - 1; i >= 0; i--) begin
            if (w_match[i]) begin
                w_mapped  = 1'b1;
                w_sel_oh  = '0;
                w_sel_oh[i] = 1'b1;
                w_sel_tag = TagW'(i);
            end
        end
    end

    always_comb begin : p_response
        w_pop         = 1'b0;
        w_stray       = 1'b0;
        host_rvalid_o = 1'b0;
        host_rdata_o  = '0;
        host_err_o    = 1'b0;
        if (!w_empty && (w_head == c_tag_err)) begin
            w_pop         = 1'b1;
            host_rvalid_o = 1'b1;
            host_err_o    = 1'b1;
        end
        for (int i = 0; i < NrDevices; i++) begin
            if (dev_rvalid_i[i]) begin
                if (!w_empty && (w_head == TagW'(i))) begin
                    w_pop         = 1'b1;
                    host_rvalid_o = 1'b1;
                    host_rdata_o  = dev_rdata_i[i];
                    host_err_o    = dev_err_i[i];
                end else begin
                    w_stray = 1'b1;
                end
            end
        end
    end

    // A pop frees a slot in the same cycle, so a full FIFO can still accept.
    assign w_space    = rst_sys_ni & (~w_full | w_pop);
    assign dev_req_o  = w_sel_oh & {NrDevices{host_req_i & w_space}};
    assign host_gnt_o = host_req_i & w_space & (w_mapped ? |(w_sel_oh & dev_gnt_i) : 1'b1);
    assign dev_addr_o = host_addr_i;
    assign w_push     = host_req_i & host_gnt_o;

    instr_router_tag_fifo #(
        .Depth (MaxOutstanding),
        .Width (TagW)
    ) u_tag_fifo (
        .clk_sys_i  (clk_sys_i),
        .rst_sys_ni (rst_sys_ni),
        .push_i     (w_push),
        .data_i     (w_sel_tag),
        .pop_i      (w_pop),
        .head_o     (w_head),
        .empty_o    (w_empty),
        .full_o     (w_full),
        .count_o    (w_count)
    );

    assign w_count_nxt = {1'b0, w_count} + (CntW+1)'(w_push) - (CntW+1)'(w_pop);

    always_ff @(posedge clk_sys_i or negedge rst_sys_ni) begin
        if (!rst_sys_ni) begin
            r_stray <= 1'b0;
            r_idle  <= 1'b1;
        end else begin
            r_stray <= r_stray | w_stray;
            r_idle  <= (w_count_nxt == '0);
        end
    end

    assign stray_rsp_o = r_stray;
    assign idle_o      = r_idle;

endmodule
`default_nettype wire

// File: tb/tb_instr_fetch_router.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : tb_instr_fetch_router                                            |
// | Brief   : Scoreboard bench: device models, in-order response checking      |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module tb_instr_fetch_router;

    logic              clk_sys_i;
    logic              rst_sys_ni;
    logic              host_req_i;
    logic              host_gnt_o;
    logic [31:0]       host_addr_i;
    logic              host_rvalid_o;
    logic [31:0]       host_rdata_o;
    logic              host_err_o;
    logic [1:0]        dev_req_o;
    logic [1:0]        dev_gnt_i;
    logic [31:0]       dev_addr_o;
    logic [1:0]        dev_rvalid_i;
    logic [1:0][31:0]  dev_rdata_i;
    logic [1:0]        dev_err_i;
    logic [1:0][31:0]  cfg_base;
    logic [1:0][31:0]  cfg_mask;
    logic              idle_o;
    logic              stray_rsp_o;

    instr_fetch_router #(
        .NrDevices      (2),
        .AddressWidth   (32),
        .DataWidth      (32),
        .MaxOutstanding (2)
    ) dut (
        .clk_sys_i              (clk_sys_i),
        .rst_sys_ni             (rst_sys_ni),
        .host_req_i             (host_req_i),
        .host_gnt_o             (host_gnt_o),
        .host_addr_i            (host_addr_i),
        .host_rvalid_o          (host_rvalid_o),
        .host_rdata_o           (host_rdata_o),
        .host_err_o             (host_err_o),
        .dev_req_o              (dev_req_o),
        .dev_gnt_i              (dev_gnt_i),
        .dev_addr_o             (dev_addr_o),
        .dev_rvalid_i           (dev_rvalid_i),
        .dev_rdata_i            (dev_rdata_i),
        .dev_err_i              (dev_err_i),
        .cfg_device_addr_base_i (cfg_base),
        .cfg_device_addr_mask_i (cfg_mask),
        .idle_o                 (idle_o),
        .stray_rsp_o            (stray_rsp_o)
    );

    initial begin
        clk_sys_i = 1'b0;
        forever #5 clk_sys_i = ~clk_sys_i;
    end

    typedef struct {
        logic [31:0] data;
        logic        err;
        int          cyc;
    } exp_t;

    typedef struct {
        int          dev;
        int          due;
        logic [31:0] data;
        logic        err;
    } rsp_t;

    exp_t        sb[$];
    rsp_t        rsp_q[$];
    logic [31:0] req_q[$];
    int          lat [2];
    bit          stray_inj [2];
    int          cycle;
    int          wait_cnt;
    int          last_wait;
    int          last_lat;
    logic [31:0] last_rdata;
    logic        last_err;
    logic        gnt_with_rsp;
    int          n_checks;
    int          n_errors;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    function automatic logic [31:0] dev_data(input int d, input logic [31:0] a);
        return (d == 0) ? (a ^ 32'h0010_0093) : (a ^ 32'h1A11_0037);
    endfunction

    // One clock cycle, entered and left at the falling edge.
    task automatic step();
        rsp_t        keep[$];
        rsp_t        r;
        exp_t        e;
        logic [1:0]  exp_oh;
        cycle++;
        dev_rvalid_i = '0;
        dev_rdata_i  = '0;
        dev_err_i    = '0;
        foreach (rsp_q[k]) begin
            if (rsp_q[k].due == cycle) begin
                dev_rvalid_i[rsp_q[k].dev] = 1'b1;
                dev_rdata_i[rsp_q[k].dev]  = rsp_q[k].data;
                dev_err_i[rsp_q[k].dev]    = rsp_q[k].err;
            end else begin
                keep.push_back(rsp_q[k]);
            end
        end
        rsp_q = keep;
        for (int d = 0; d < 2; d++) begin
            if (stray_inj[d] && !dev_rvalid_i[d]) begin
                dev_rvalid_i[d] = 1'b1;
                dev_rdata_i[d]  = 32'hBAD0_0000 | d;
            end
            stray_inj[d] = 1'b0;
        end
        host_req_i = (req_q.size() != 0);
        if (host_req_i) host_addr_i = req_q[0];
        #1;
        if (host_req_i) check("dev_addr", dev_addr_o, host_addr_i);
        if (host_rvalid_o) begin
            if (sb.size() == 0) begin
                check("rsp_unexpected", {31'b0, host_rvalid_o}, 32'd0);
            end else begin
                e = sb.pop_front();
                check("rdata", host_rdata_o, e.data);
                check("rerr", {31'b0, host_err_o}, {31'b0, e.err});
                last_lat   = cycle - e.cyc;
                last_rdata = host_rdata_o;
                last_err   = host_err_o;
            end
        end
        if (host_req_i) begin
            if (host_gnt_o) begin
                if ((host_addr_i & 32'hFFFF_0000) == 32'h0010_0000) begin
                    exp_oh = 2'b01; e.data = dev_data(0, host_addr_i); e.err = 1'b0;
                end else if ((host_addr_i & 32'hFFFF_0000) == 32'h1A11_0000) begin
                    exp_oh = 2'b10; e.data = dev_data(1, host_addr_i); e.err = host_addr_i[3];
                end else begin
                    exp_oh = 2'b00; e.data = 32'h0; e.err = 1'b1;
                end
                check("dev_req", {30'b0, dev_req_o}, {30'b0, exp_oh});
                e.cyc = cycle;
                sb.push_back(e);
                void'(req_q.pop_front());
                last_wait    = wait_cnt;
                wait_cnt     = 0;
                gnt_with_rsp = host_rvalid_o;
            end else begin
                wait_cnt++;
            end
        end
        for (int d = 0; d < 2; d++) begin
            if (dev_req_o[d] && dev_gnt_i[d]) begin
                r.dev  = d;
                r.due  = cycle + lat[d];
                r.data = dev_data(d, dev_addr_o);
                r.err  = (d == 1) && dev_addr_o[3];
                rsp_q.push_back(r);
            end
        end
        @(negedge clk_sys_i);
    endtask

    task automatic drain(input int max_cycles);
        int n;
        n = 0;
        while ((sb.size() != 0 || req_q.size() != 0) && n < max_cycles) begin
            step();
            n++;
        end
        check("drain_timeout", sb.size() + req_q.size(), 32'd0);
    endtask

    // Outstanding device responses are left in flight so they arrive after reset.
    task automatic do_reset();
        dev_rvalid_i = '0;
        rst_sys_ni   = 1'b0;
        host_req_i   = 1'b1;
        host_addr_i  = 32'h4000_0000;
        #1;
        check("rst_gnt", {31'b0, host_gnt_o}, 32'd0);
        host_addr_i = 32'h0010_0000;
        #1;
        check("rst_dev_req", {30'b0, dev_req_o}, 32'd0);
        check("rst_idle", {31'b0, idle_o}, 32'd1);
        check("rst_rvalid", {31'b0, host_rvalid_o}, 32'd0);
        check("rst_rdata", host_rdata_o, 32'd0);
        check("rst_stray", {31'b0, stray_rsp_o}, 32'd0);
        sb.delete();
        req_q.delete();
        wait_cnt = 0;
        @(posedge clk_sys_i);
        @(negedge clk_sys_i);
        host_req_i = 1'b0;
        #1 rst_sys_ni = 1'b1;
        @(negedge clk_sys_i);
    endtask

    initial begin
        n_checks = 0; n_errors = 0; cycle = 0; wait_cnt = 0; last_wait = 0;
        last_lat = 0; last_rdata = '0; last_err = 1'b0; gnt_with_rsp = 1'b0;
        lat[0] = 1; lat[1] = 1; stray_inj[0] = 1'b0; stray_inj[1] = 1'b0;
        rst_sys_ni = 1'b0; host_req_i = 1'b0; host_addr_i = '0;
        dev_gnt_i = 2'b11; dev_rvalid_i = '0; dev_rdata_i = '0; dev_err_i = '0;
        cfg_base[0] = 32'h0010_0000; cfg_mask[0] = 32'hFFFF_0000;
        cfg_base[1] = 32'h1A11_0000; cfg_mask[1] = 32'hFFFF_0000;
        @(negedge clk_sys_i);
        do_reset();

        // RAM fetch, one-cycle response
        req_q.push_back(32'h0010_0080);
        step();
        check("t1_busy", {31'b0, idle_o}, 32'd0);
        drain(20);
        check("t1_data", last_rdata, 32'h0000_0013);
        check("t1_lat", last_lat, 32'd1);
        check("t1_idle", {31'b0, idle_o}, 32'd1);
        check("t1_stray", {31'b0, stray_rsp_o}, 32'd0);

        // debug-memory fetch with a dev0 stray alongside, then a device error
        req_q.push_back(32'h1A11_0800);
        step();
        stray_inj[0] = 1'b1;
        drain(20);
        check("t2_data", last_rdata, 32'h0000_0837);
        check("t2_stray", {31'b0, stray_rsp_o}, 32'd1);
        req_q.push_back(32'h1A11_0808);
        drain(20);
        check("t2_dev_err", {31'b0, last_err}, 32'd1);
        do_reset();

        // unmapped fetch
        req_q.push_back(32'h4000_0000);
        drain(20);
        check("t3_wait", last_wait, 32'd0);
        check("t3_lat", last_lat, 32'd1);
        check("t3_err", {31'b0, last_err}, 32'd1);
        check("t3_rdata", last_rdata, 32'd0);

        // back-to-back into a slow device: third fetch waits for the first pop
        lat[0] = 3;
        req_q.push_back(32'h0010_0000);
        req_q.push_back(32'h0010_0004);
        req_q.push_back(32'h0010_0008);
        drain(40);
        check("t4_wait", last_wait, 32'd1);
        check("t4_gnt_in_pop", {31'b0, gnt_with_rsp}, 32'd1);
        check("t4_last_data", last_rdata, 32'h0000_009B);
        lat[0] = 1;
        do_reset();

        // interleaved devices with a dev1 response arriving while dev0 is head
        lat[0] = 2; lat[1] = 2;
        req_q.push_back(32'h0010_0000);
        req_q.push_back(32'h1A11_0000);
        req_q.push_back(32'h4000_0000);
        step();
        check("t5_stray_pre", {31'b0, stray_rsp_o}, 32'd0);
        stray_inj[1] = 1'b1;
        drain(40);
        check("t5_stray", {31'b0, stray_rsp_o}, 32'd1);
        check("t5_last_err", {31'b0, last_err}, 32'd1);
        lat[0] = 1; lat[1] = 1;

        // reset with two fetches outstanding; late responses become strays
        do_reset();
        lat[0] = 3;
        req_q.push_back(32'h0010_0000);
        req_q.push_back(32'h0010_0010);
        step();
        step();
        check("t6_busy", {31'b0, idle_o}, 32'd0);
        do_reset();
        repeat (4) step();
        check("t6_late_stray", {31'b0, stray_rsp_o}, 32'd1);
        check("t6_idle", {31'b0, idle_o}, 32'd1);
        lat[0] = 1;
        req_q.push_back(32'h0010_0004);
        drain(20);
        check("t6_data", last_rdata, 32'h0000_0097);
        check("t6_lat", last_lat, 32'd1);
        check("t6_idle_end", {31'b0, idle_o}, 32'd1);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1);
    end

endmodule
`default_nettype wire
